dmem_lsu: RTL and testbench

DMEM_LSU -- requirements
Module: dmem_lsu

---
 rtl/dmem_pkg.sv | 24 ++
 rtl/dmem_align.sv | 61 ++++++
 rtl/dmem_lsu.sv | 142 ++++++++++++++
 tb/tb_dmem_lsu.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory load/store unit.
// Holds the RV32I funct3 size/sign codes used by loads and stores and the
// encoding of the request-handling FSM.
package dmem_pkg;

    // Load codes
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Store codes (share encodings with the signed loads)
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/dmem_align.sv
// Combinational alignment helper for dmem_lsu.
// Ports:
//   funct3   in   RV32I size/sign code
//   offset   in   byte offset within the word (addr[1:0])
//   wdata    in   right-aligned store data
//   rword    in   current contents of the addressed word
//   be       out  per-byte write enables for a store of this size/offset
//   wword    out  store data replicated onto every lane (be picks the lanes)
//   ldata    out  extracted and sign/zero-extended load result
//   misalign out  halfword on odd address or word on non-zero offset
module dmem_align
    import dmem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wword,
    output logic [31:0] ldata,
    output logic        misalign
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rword[{offset, 3'b000} +: 8];
        half_sel = offset[1] ? rword[31:16] : rword[15:0];
        misalign = ((funct3[1:0] == 2'b01) && offset[0]) ||
                   ((funct3[1:0] == 2'b10) && (offset != 2'b00));

        // Replicating the data onto all lanes lets the byte enables alone
        // pick the destination, so no shifter is needed.
        be    = 4'b0000;
        wword = wdata;
        case (funct3[1:0])
            2'b00: begin
                be    = 4'b0001 << offset;
                wword = {4{wdata[7:0]}};
            end
            2'b01: begin
                be    = 4'b0011 << offset;
                wword = {2{wdata[15:0]}};
            end
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase

        ldata = '0;
        case (funct3)
            F3_LB:   ldata = {{24{byte_sel[7]}}, byte_sel};
            F3_LH:   ldata = {{16{half_sel[15]}}, half_sel};
            F3_LW:   ldata = rword;
            F3_LBU:  ldata = {24'd0, byte_sel};
            F3_LHU:  ldata = {16'd0, half_sel};
            default: ldata = '0;
        endcase
    end

endmodule

// File: rtl/dmem_lsu.sv
// Data-memory load/store unit: a single-outstanding request port in front of
// a word-organised memory array, with configurable access wait cycles.
// Ports:
//   clk, rst            clock and asynchronous active-high reset
//   req_valid/req_ready request handshake; accept when both high on an edge
//   req_we              1 = store, 0 = load
//   req_funct3          RV32I size/sign code
//   req_addr            byte address
//   req_wdata           right-aligned store data
//   rsp_valid           one-cycle response strobe
//   rsp_rdata           extended load result (0 for stores and errors)
//   rsp_err             request was illegal; nothing was written
module dmem_lsu
    import dmem_pkg::*;
#(
    parameter int Width      = 32,
    parameter int Depth      = 64,
    parameter int WaitCycles = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [2:0]       req_funct3,
    input  logic [Width-1:0] req_addr,
    input  logic [Width-1:0] req_wdata,
    output logic             rsp_valid,
    output logic [Width-1:0] rsp_rdata,
    output logic             rsp_err
);

    if (Width != 32) begin : g_bad_width
        $error("dmem_lsu: Width must be 32");
    end
    if ((Depth < 4) || ((Depth & (Depth - 1)) != 0)) begin : g_bad_depth
        $error("dmem_lsu: Depth must be a power of two, at least 4");
    end
    if ((WaitCycles < 0) || (WaitCycles > 15)) begin : g_bad_wait
        $error("dmem_lsu: WaitCycles must be in 0..15");
    end

    localparam int AW = $clog2(Depth);

    state_t           state, state_nx;
    logic [3:0]       cnt;
    logic             accept, access, wr_en;

    logic             cap_we;
    logic [2:0]       cap_f3;
    logic [Width-1:0] cap_addr, cap_wdata;

    // Operands seen on the access edge: with no wait cycles the access edge
    // is the accept edge, so the live request is used directly.
    logic             op_we;
    logic [2:0]       op_f3;
    logic [Width-1:0] op_addr, op_wdata;
    logic [AW-1:0]    op_idx;

    logic [Width-1:0] mem [Depth];
    logic [Width-1:0] rword, wword, ldata;
    logic [3:0]       be;
    logic             misalign, bad_f3, oob, err;

    assign req_ready = (state == ST_IDLE) && !rst;
    assign accept    = req_valid && req_ready;
    assign access    = (WaitCycles == 0) ? accept : ((state == ST_WAIT) && (cnt == 4'd0));
    assign rsp_valid = (state == ST_DONE);

    assign op_we    = (WaitCycles == 0) ? req_we     : cap_we;
    assign op_f3    = (WaitCycles == 0) ? req_funct3 : cap_f3;
    assign op_addr  = (WaitCycles == 0) ? req_addr   : cap_addr;
    assign op_wdata = (WaitCycles == 0) ? req_wdata  : cap_wdata;
    assign op_idx   = op_addr[AW+1:2];

    assign rword  = mem[op_idx];
    assign bad_f3 = (op_f3 == 3'b011) || (op_f3[2:1] == 2'b11) || (op_we && op_f3[2]);
    assign oob    = |op_addr[Width-1:AW+2];
    assign err    = bad_f3 || misalign || oob;
    // rst is checked here too so a store whose access edge coincides with
    // reset is dropped rather than committed.
    assign wr_en  = access && !rst && op_we && !err;

    dmem_align u_align (
        .funct3   (op_f3),
        .offset   (op_addr[1:0]),
        .wdata    (op_wdata),
        .rword    (rword),
        .be       (be),
        .wword    (wword),
        .ldata    (ldata),
        .misalign (misalign)
    );

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (accept) state_nx = (WaitCycles == 0) ? ST_DONE : ST_WAIT;
            ST_WAIT: if (cnt == 4'd0) state_nx = ST_DONE;
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= 4'd0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            state <= state_nx;
            if (accept)
                cnt <= (WaitCycles > 0) ? 4'(WaitCycles - 1) : 4'd0;
            else if ((state == ST_WAIT) && (cnt != 4'd0))
                cnt <= cnt - 4'd1;
            if (access) begin
                rsp_err   <= err;
                rsp_rdata <= (err || op_we) ? '0 : ldata;
            end
        end
    end

    // Request capture; contents are only meaningful while a request is held.
    always_ff @(posedge clk) begin
        if (accept) begin
            cap_we    <= req_we;
            cap_f3    <= req_funct3;
            cap_addr  <= req_addr;
            cap_wdata <= req_wdata;
        end
    end

    // Memory array is deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) mem[op_idx][8*b +: 8] <= wword[8*b +: 8];
        end
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// Self-checking bench for dmem_lsu. Three instances (WaitCycles 1, 0, 3)
// share clock and reset; a byte-array memory model predicts every response.
module tb_dmem_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid [3];
    logic        req_ready [3];
    logic        req_we    [3];
    logic [2:0]  req_funct3[3];
    logic [31:0] req_addr  [3];
    logic [31:0] req_wdata [3];
    logic        rsp_valid [3];
    logic [31:0] rsp_rdata [3];
    logic        rsp_err   [3];

    int checks = 0;
    int passed = 0;

    logic [7:0] mb [3][256];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        dmem_lsu #(
            .Width(32), .Depth(64), .WaitCycles((g == 0) ? 1 : ((g == 1) ? 0 : 3))
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .req_valid  (req_valid[g]),
            .req_ready  (req_ready[g]),
            .req_we     (req_we[g]),
            .req_funct3 (req_funct3[g]),
            .req_addr   (req_addr[g]),
            .req_wdata  (req_wdata[g]),
            .rsp_valid  (rsp_valid[g]),
            .rsp_rdata  (rsp_rdata[g]),
            .rsp_err    (rsp_err[g])
        );
    end

    function automatic int wc(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 0 : 3);
    endfunction

    // Reference: byte-addressed little-endian memory, errors by the rule list.
    task automatic model(input int k, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic err, output logic [31:0] rd);
        int sz;
        int a;
        logic [31:0] v;
        sz  = (f3[1:0] == 2'd0) ? 1 : ((f3[1:0] == 2'd1) ? 2 : 4);
        err = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (we && f3[2]) ||
              (addr % sz != 0) || (addr >= 32'd256);
        rd  = 32'd0;
        if (!err) begin
            a = int'(addr);
            if (we) begin
                for (int i = 0; i < sz; i++) mb[k][a+i] = wdata[8*i +: 8];
            end else begin
                v = 32'd0;
                for (int i = 0; i < sz; i++) v[8*i +: 8] = mb[k][a+i];
                if (!f3[2] && sz < 4 && v[8*sz-1])
                    for (int j = 8*sz; j < 32; j++) v[j] = 1'b1;
                rd = v;
            end
        end
    endtask

    function automatic logic [31:0] model_word(input int k, input int a);
        return {mb[k][a+3], mb[k][a+2], mb[k][a+1], mb[k][a]};
    endfunction

    task automatic gen_req(output logic we, output logic [2:0] f3,
                           output logic [31:0] addr, output logic [31:0] wdata);
        logic [2:0] legal [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        we = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 3) != 0) f3 = legal[$urandom_range(0, 4)];
        else f3 = 3'($urandom_range(0, 7));
        if ($urandom_range(0, 9) == 0) addr = $urandom;
        else begin
            addr = 32'($urandom_range(0, 255));
            if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
        end
        wdata = $urandom;
    endtask

    // Drives one request and returns what came back; lat = -1 on timeout.
    // Starts and ends on a falling edge.
    task automatic run_xact(input int k, input logic we, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            output int lat, output logic [31:0] rd,
                            output logic er, output logic held);
        int n;
        lat = -1; rd = 'x; er = 1'bx; held = 1'b0;
        n = 0;
        while (req_ready[k] !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        if (n >= 40) return;
        req_valid[k] = 1'b1; req_we[k] = we; req_funct3[k] = f3;
        req_addr[k] = addr;  req_wdata[k] = wdata;
        @(posedge clk);
        @(negedge clk);
        req_valid[k] = 1'b0;
        n = 0;
        while (rsp_valid[k] !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        if (n >= 40) return;
        lat = n; rd = rsp_rdata[k]; er = rsp_err[k];
        @(negedge clk);
        held = (rsp_valid[k] === 1'b0) && (rsp_rdata[k] === rd) && (rsp_err[k] === er);
    endtask

    task automatic test_reset;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (req_ready[k] !== 1'b0 || rsp_valid[k] !== 1'b0 ||
                rsp_rdata[k] !== 32'd0 || rsp_err[k] !== 1'b0)
                $display("FAIL reset_state k=%0d got rdy=%b vld=%b rd=%h err=%b exp 0 0 0 0",
                         k, req_ready[k], rsp_valid[k], rsp_rdata[k], rsp_err[k]);
            else passed++;
        end
    endtask

    // Fills every word so later loads compare against known contents.
    task automatic test_init;
        int lat; logic [31:0] rd, erd, wd; logic er, eer, held;
        for (int k = 0; k < 3; k++)
            for (int w = 0; w < 64; w++) begin
                wd = $urandom;
                model(k, 1'b1, 3'd2, 32'(w*4), wd, eer, erd);
                run_xact(k, 1'b1, 3'd2, 32'(w*4), wd, lat, rd, er, held);
                checks++;
                if (lat != wc(k) || er !== eer || rd !== erd)
                    $display("FAIL init_sw k=%0d w=%0d got lat=%0d err=%b rd=%h exp lat=%0d err=%b rd=%h",
                             k, w, lat, er, rd, wc(k), eer, erd);
                else passed++;
            end
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rd;
        logic        err;
    } dir_t;

    task automatic test_directed;
        dir_t tbl[13];
        int lat; logic [31:0] rd, mrd; logic er, mer, held;
        tbl[0]  = '{1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0};
        tbl[1]  = '{1'b0, 3'b010, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0};
        tbl[2]  = '{1'b1, 3'b000, 32'h11, 32'h0000005A, 32'h0,        1'b0};
        tbl[3]  = '{1'b0, 3'b010, 32'h10, 32'h0,        32'hDEAD5AEF, 1'b0};
        tbl[4]  = '{1'b0, 3'b000, 32'h11, 32'h0,        32'h0000005A, 1'b0};
        tbl[5]  = '{1'b0, 3'b100, 32'h13, 32'h0,        32'h000000DE, 1'b0};
        tbl[6]  = '{1'b0, 3'b000, 32'h13, 32'h0,        32'hFFFFFFDE, 1'b0};
        tbl[7]  = '{1'b0, 3'b001, 32'h12, 32'h0,        32'hFFFFDEAD, 1'b0};
        tbl[8]  = '{1'b0, 3'b010, 32'h12, 32'h0,        32'h0,        1'b1};
        tbl[9]  = '{1'b1, 3'b001, 32'h13, 32'h0000BEEF, 32'h0,        1'b1};
        tbl[10] = '{1'b0, 3'b001, 32'h11, 32'h0,        32'h0,        1'b1};
        tbl[11] = '{1'b0, 3'b011, 32'h10, 32'h0,        32'h0,        1'b1};
        tbl[12] = '{1'b0, 3'b010, 32'h10, 32'h0,        32'hDEAD5AEF, 1'b0};
        for (int i = 0; i < 13; i++) begin
            model(0, tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata, mer, mrd);
            run_xact(0, tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata, lat, rd, er, held);
            checks++;
            if (lat != 1 || rd !== tbl[i].rd || er !== tbl[i].err)
                $display("FAIL directed #%0d got lat=%0d rd=%h err=%b exp lat=1 rd=%h err=%b",
                         i, lat, rd, er, tbl[i].rd, tbl[i].err);
            else passed++;
        end
    endtask

    task automatic test_out_of_range;
        int lat; logic [31:0] rd, erd; logic er, eer, held;
        run_xact(0, 1'b1, 3'b010, 32'h100, 32'hCAFEF00D, lat, rd, er, held);
        checks++;
        if (lat != 1 || er !== 1'b1 || rd !== 32'd0)
            $display("FAIL oob_sw got lat=%0d err=%b rd=%h exp lat=1 err=1 rd=0", lat, er, rd);
        else passed++;
        for (int w = 0; w < 64; w++) begin
            model(0, 1'b0, 3'b010, 32'(w*4), 32'd0, eer, erd);
            run_xact(0, 1'b0, 3'b010, 32'(w*4), 32'd0, lat, rd, er, held);
            checks++;
            if (rd !== erd || er !== 1'b0)
                $display("FAIL oob_intact w=%0d got rd=%h err=%b exp rd=%h err=0", w, rd, er, erd);
            else passed++;
        end
    endtask

    task automatic test_random;
        logic we; logic [2:0] f3; logic [31:0] addr, wd, rd, erd;
        int lat; logic er, eer, held;
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < 60; i++) begin
                gen_req(we, f3, addr, wd);
                model(k, we, f3, addr, wd, eer, erd);
                run_xact(k, we, f3, addr, wd, lat, rd, er, held);
                checks++;
                if (lat != wc(k) || rd !== erd || er !== eer || !held)
                    $display("FAIL random k=%0d we=%b f3=%0d a=%h got lat=%0d rd=%h err=%b held=%b exp lat=%0d rd=%h err=%b held=1",
                             k, we, f3, addr, lat, rd, er, held, wc(k), erd, eer);
                else passed++;
            end
    endtask

    task automatic test_back_to_back;
        logic we; logic [2:0] f3; logic [31:0] addr, wd, erd;
        logic eer, acc, exp_rdy;
        logic [32:0] q[$];
        logic [32:0] e;
        int last;
        for (int k = 1; k < 3; k++) begin
            q.delete();
            last = -1000;
            gen_req(we, f3, addr, wd);
            req_valid[k] = 1'b1; req_we[k] = we; req_funct3[k] = f3;
            req_addr[k] = addr;  req_wdata[k] = wd;
            for (int cyc = 0; cyc < 40; cyc++) begin
                exp_rdy = (cyc - last >= wc(k) + 2);
                checks++;
                if (req_ready[k] !== exp_rdy)
                    $display("FAIL b2b_ready k=%0d cyc=%0d got %b exp %b", k, cyc, req_ready[k], exp_rdy);
                else passed++;
                if (rsp_valid[k] === 1'b1) begin
                    checks++;
                    if (q.size() == 0)
                        $display("FAIL b2b_rsp k=%0d cyc=%0d got unexpected response exp none", k, cyc);
                    else begin
                        e = q.pop_front();
                        if ({rsp_err[k], rsp_rdata[k]} !== e)
                            $display("FAIL b2b_rsp k=%0d cyc=%0d got err=%b rd=%h exp err=%b rd=%h",
                                     k, cyc, rsp_err[k], rsp_rdata[k], e[32], e[31:0]);
                        else passed++;
                    end
                end
                acc = (req_ready[k] === 1'b1);
                if (acc) begin
                    model(k, we, f3, addr, wd, eer, erd);
                    q.push_back({eer, erd});
                    if (last > -1000) begin
                        checks++;
                        if (cyc - last != wc(k) + 2)
                            $display("FAIL b2b_spacing k=%0d got %0d exp %0d", k, cyc - last, wc(k) + 2);
                        else passed++;
                    end
                    last = cyc;
                end
                @(posedge clk);
                #1;
                if (acc) begin
                    gen_req(we, f3, addr, wd);
                    req_we[k] = we; req_funct3[k] = f3; req_addr[k] = addr; req_wdata[k] = wd;
                end
                @(negedge clk);
            end
            req_valid[k] = 1'b0;
            for (int d = 0; d < wc(k) + 3; d++) begin
                if (rsp_valid[k] === 1'b1 && q.size() != 0) begin
                    e = q.pop_front();
                    checks++;
                    if ({rsp_err[k], rsp_rdata[k]} !== e)
                        $display("FAIL b2b_drain k=%0d got err=%b rd=%h exp err=%b rd=%h",
                                 k, rsp_err[k], rsp_rdata[k], e[32], e[31:0]);
                    else passed++;
                end
                @(negedge clk);
            end
            checks++;
            if (q.size() != 0)
                $display("FAIL b2b_missing k=%0d got %0d outstanding exp 0", k, q.size());
            else passed++;
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] prior, rd;
        int lat, n; logic er, held, saw;
        prior = model_word(0, 32'h20);
        run_xact(0, 1'b0, 3'b010, 32'h20, 32'd0, lat, rd, er, held);
        checks++;
        if (rd !== prior || er !== 1'b0)
            $display("FAIL rst_pre_lw got rd=%h err=%b exp rd=%h err=0", rd, er, prior);
        else passed++;
        n = 0;
        while (req_ready[0] !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        req_valid[0] = 1'b1; req_we[0] = 1'b1; req_funct3[0] = 3'b010;
        req_addr[0] = 32'h20; req_wdata[0] = 32'h00001234;
        @(posedge clk);
        @(negedge clk);
        req_valid[0] = 1'b0;
        checks++;
        if (req_ready[0] !== 1'b0)
            $display("FAIL rst_wait_ready got %b exp 0", req_ready[0]);
        else passed++;
        rst = 1'b1;
        #1;
        checks++;
        if (rsp_rdata[0] !== 32'd0 || rsp_err[0] !== 1'b0 || req_ready[0] !== 1'b0)
            $display("FAIL rst_clear got rd=%h err=%b rdy=%b exp rd=0 err=0 rdy=0",
                     rsp_rdata[0], rsp_err[0], req_ready[0]);
        else passed++;
        saw = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 1) rst = 1'b0;
            if (rsp_valid[0] === 1'b1) saw = 1'b1;
        end
        checks++;
        if (saw !== 1'b0) $display("FAIL rst_no_rsp got rsp_valid=1 exp 0");
        else passed++;
        run_xact(0, 1'b0, 3'b010, 32'h20, 32'd0, lat, rd, er, held);
        checks++;
        if (rd !== prior || er !== 1'b0 || lat != 1)
            $display("FAIL rst_abandon got rd=%h err=%b lat=%0d exp rd=%h err=0 lat=1", rd, er, lat, prior);
        else passed++;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            req_valid[k] = 1'b0; req_we[k] = 1'b0; req_funct3[k] = 3'd0;
            req_addr[k] = 32'd0; req_wdata[k] = 32'd0;
        end
        @(negedge clk);
        @(negedge clk);
        test_reset;
        rst = 1'b0;
        test_init;
        test_directed;
        test_out_of_range;
        test_random;
        test_back_to_back;
        test_reset_mid;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
